// File: rtl/icache_types.sv
// Shared types for the instruction cache: FSM states and line geometry.
package icache_types;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] FILL = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam int OFFSET_W  = 5;
  localparam int WSEL_W    = 3;
  localparam int BEAT_W    = 2;
  localparam int LINE_BITS = 256;

  function automatic logic [31:0] line_word(
    input logic [LINE_BITS-1:0] line,
    input logic [WSEL_W-1:0]    sel
  );
    return line[{sel, 5'd0} +: 32];
  endfunction

endpackage

// File: rtl/icache_array.sv
// Direct-mapped tag/valid/data store: async read, sync write, flush-clear.
module icache_array
  import icache_types::*;
#(
  parameter int NUM_SETS = 16,
  parameter int IDX_W    = $clog2(NUM_SETS),
  parameter int TAG_W    = 32 - IDX_W - OFFSET_W
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic [TAG_W-1:0]     rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 we,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic                 wr_valid,
  input  logic [TAG_W-1:0]     wr_tag,
  input  logic [LINE_BITS-1:0] wr_data
);

  logic [NUM_SETS-1:0]  valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_SETS];
  logic [LINE_BITS-1:0] data_mem [NUM_SETS];

  // Flush takes priority so a fill completing alongside it stays invalid
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid <= '0;
    end else if (flush) begin
      valid <= '0;
    end else if (we) begin
      valid[wr_idx] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tag_mem[rd_idx];
  assign rd_data  = data_mem[rd_idx];

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache with zero-cycle hits and burst line fill.
// Optional hit/miss counters with INST_CACHE_PERF_CNT_EN.
module inst_cache
  import icache_types::*;
#(
  parameter int NUM_SETS   = 16,
  parameter int LINE_BEATS = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        inst_read,
  input  logic [31:0] inst_addr,
  input  logic        flush,
  output logic [31:0] inst_rdata,
  output logic        inst_resp,
  output logic        pmem_read,
  output logic [31:0] pmem_address,
  input  logic [63:0] pmem_rdata,
`ifdef INST_CACHE_PERF_CNT_EN
  input  logic        pmem_resp,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
`else
  input  logic        pmem_resp
`endif
);

  localparam int IDX_W = $clog2(NUM_SETS);
  localparam int TAG_W = 32 - IDX_W - OFFSET_W;
  localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LINE_BEATS - 1);

  logic [1:0]           state;
  logic [31:2]          addr_q;
  logic [BEAT_W-1:0]    cnt;
  logic [LINE_BITS-1:0] fill_buf;
  logic                 flush_pend;

  logic                 rd_valid;
  logic [TAG_W-1:0]     rd_tag;
  logic [LINE_BITS-1:0] rd_data;
  logic                 hit;
  logic                 idle_hit;
  logic                 idle_miss;
  logic [1:0]           unused_addr;

  assign unused_addr = inst_addr[1:0];

  icache_array #(
    .NUM_SETS (NUM_SETS)
  ) u_array (
    .clk      (clk),
    .reset_n  (reset_n),
    .flush    (flush),
    .rd_idx   (inst_addr[IDX_W+OFFSET_W-1:OFFSET_W]),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_data  (rd_data),
    .we       (state == RESP),
    .wr_idx   (addr_q[IDX_W+OFFSET_W-1:OFFSET_W]),
    .wr_valid (!flush_pend),
    .wr_tag   (addr_q[31:IDX_W+OFFSET_W]),
    .wr_data  (fill_buf)
  );

  assign hit       = rd_valid && (rd_tag == inst_addr[31:IDX_W+OFFSET_W]);
  assign idle_hit  = (state == IDLE) && inst_read && hit;
  assign idle_miss = (state == IDLE) && inst_read && !hit;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt        <= '0;
      fill_buf   <= '0;
      flush_pend <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          flush_pend <= 1'b0;
          if (idle_miss) begin
            addr_q <= inst_addr[31:2];
            cnt    <= '0;
            state  <= FILL;
          end
        end
        FILL: begin
          if (flush) flush_pend <= 1'b1;
          if (pmem_resp) begin
            fill_buf[{cnt, 6'd0} +: 64] <= pmem_rdata;
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= RESP;
          end
        end
        RESP: begin
          flush_pend <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pmem_read    = (state == FILL);
  assign pmem_address = {addr_q[31:OFFSET_W], 5'd0};

  always_comb begin
    inst_resp  = 1'b0;
    inst_rdata = '0;
    if (idle_hit) begin
      inst_resp  = 1'b1;
      inst_rdata = line_word(rd_data, inst_addr[4:2]);
    end else if (state == RESP) begin
      inst_resp  = 1'b1;
      inst_rdata = line_word(fill_buf, addr_q[4:2]);
    end
  end

`ifdef INST_CACHE_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (idle_hit)  hit_count  <= hit_count + 32'd1;
      if (idle_miss) miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed self-checking bench for inst_cache.
// Memory word at byte address A is A + 0x1000_0000, except line 0x100.
module tb_inst_cache;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        inst_read;
  logic [31:0] inst_addr;
  logic        flush;
  logic [31:0] inst_rdata;
  logic        inst_resp;
  logic        pmem_read;
  logic [31:0] pmem_address;
  logic [63:0] pmem_rdata;
  logic        pmem_resp;
`ifdef INST_CACHE_PERF_CNT_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  inst_cache dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .inst_read    (inst_read),
    .inst_addr    (inst_addr),
    .flush        (flush),
    .inst_rdata   (inst_rdata),
    .inst_resp    (inst_resp),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
`ifdef INST_CACHE_PERF_CNT_EN
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`else
    .pmem_resp    (pmem_resp)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] beat(input logic [31:0] line, input int k);
    if (line == 32'h100) begin
      case (k)
        0: return {32'h1111_0001, 32'h1111_0000};
        1: return {32'h2222_0001, 32'h2222_0000};
        2: return {32'h3333_0001, 32'h3333_0000};
        default: return {32'h4444_0001, 32'h4444_0000};
      endcase
    end
    return {line + 32'h1000_0004 + 32'(8 * k),
            line + 32'h1000_0000 + 32'(8 * k)};
  endfunction

  task automatic read_miss(input logic [31:0] a, input logic [31:0] exp,
                           input int flush_beat);
    logic [31:0] line;
    line = {a[31:5], 5'd0};
    @(negedge clk);
    inst_read = 1'b1;
    inst_addr = a;
    flush     = 1'b0;
    #1;
    chkb("miss_resp", inst_resp, 1'b0);
    chk("miss_rdata", inst_rdata, 32'h0);
    chkb("miss_noreq", pmem_read, 1'b0);
    @(negedge clk);
    inst_read = 1'b0;
    inst_addr = a ^ 32'h0000_0FE0;
    for (int k = 0; k < 4; k++) begin
      if (k == 1) begin
        pmem_resp = 1'b0;
        #1;
        chkb("fill_hold", pmem_read, 1'b1);
        @(negedge clk);
      end
      pmem_resp  = 1'b1;
      pmem_rdata = beat(line, k);
      flush      = (k == flush_beat);
      #1;
      chkb("fill_req", pmem_read, 1'b1);
      chk("fill_addr", pmem_address, line);
      chkb("fill_noresp", inst_resp, 1'b0);
      @(negedge clk);
    end
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    flush      = 1'b0;
    #1;
    chkb("resp_valid", inst_resp, 1'b1);
    chk("resp_data", inst_rdata, exp);
    chkb("resp_noreq", pmem_read, 1'b0);
  endtask

  task automatic hit(input logic [31:0] a, input logic [31:0] exp,
                     input logic fl);
    @(negedge clk);
    inst_read = 1'b1;
    inst_addr = a;
    flush     = fl;
    #1;
    chkb("hit_resp", inst_resp, 1'b1);
    chk("hit_data", inst_rdata, exp);
    chkb("hit_noreq", pmem_read, 1'b0);
  endtask

  initial begin
    reset_n    = 1'b0;
    inst_read  = 1'b0;
    inst_addr  = '0;
    flush      = 1'b0;
    pmem_rdata = '0;
    pmem_resp  = 1'b0;
    #1;
    chkb("rst_resp", inst_resp, 1'b0);
    chkb("rst_pmem_read", pmem_read, 1'b0);
    chk("rst_rdata", inst_rdata, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // Cold miss then zero-cycle hits
    read_miss(32'h40, 32'h1000_0040, -1);
    hit(32'h40, 32'h1000_0040, 1'b0);
    hit(32'h44, 32'h1000_0044, 1'b0);
    hit(32'h5C, 32'h1000_005C, 1'b0);
    @(negedge clk);
    inst_read = 1'b0;
    #1;
    chkb("idle_resp", inst_resp, 1'b0);
    chk("idle_rdata", inst_rdata, 32'h0);
    chkb("idle_noreq", pmem_read, 1'b0);
`ifdef INST_CACHE_PERF_CNT_EN
    chk("miss_count", miss_count, 32'd1);
    chk("hit_count", hit_count, 32'd3);
`endif

    // Conflict on set 2
    read_miss(32'h240, 32'h1000_0240, -1);
    hit(32'h248, 32'h1000_0248, 1'b0);
    read_miss(32'h40, 32'h1000_0040, -1);

    // Word select within one line
    read_miss(32'h100, 32'h1111_0000, -1);
    hit(32'h104, 32'h1111_0001, 1'b0);
    hit(32'h11C, 32'h4444_0001, 1'b0);
    hit(32'h110, 32'h3333_0000, 1'b0);

    // Flush in IDLE: same-cycle hit still served, then misses
    hit(32'h104, 32'h1111_0001, 1'b1);
    read_miss(32'h104, 32'h1111_0001, -1);

    // Flush during fill leaves the line invalid
    read_miss(32'h80, 32'h1000_0080, 2);
    read_miss(32'h88, 32'h1000_0088, -1);
    hit(32'h84, 32'h1000_0084, 1'b0);

    // Reset during beat 1 abandons the fill
    @(negedge clk);
    flush     = 1'b0;
    inst_read = 1'b1;
    inst_addr = 32'h300;
    #1;
    chkb("rst_miss", inst_resp, 1'b0);
    @(negedge clk);
    inst_read  = 1'b0;
    pmem_resp  = 1'b1;
    pmem_rdata = beat(32'h300, 0);
    @(negedge clk);
    pmem_rdata = beat(32'h300, 1);
    reset_n    = 1'b0;
    #1;
    chkb("rst_fill_read", pmem_read, 1'b0);
    chkb("rst_fill_resp", inst_resp, 1'b0);
    @(negedge clk);
    pmem_resp = 1'b0;
    reset_n   = 1'b1;
    read_miss(32'h300, 32'h1000_0300, -1);
    read_miss(32'h84, 32'h1000_0084, -1);

    @(negedge clk);
    inst_read = 1'b0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
